// File: rtl/i2s_tx_stereo24.sv
// i2s_tx_stereo24: stereo 24-bit I2S / left-justified serializer driven by an external bit strobe,
// with sample requests, repeat-on-underrun and a saturating underrun counter.
module i2s_tx_stereo24 #(
    parameter int SAMPLE_BITS = 24,
    parameter int SLOT_BITS   = 32,
    parameter int I2S_DELAY   = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        strobe,
    input  logic [23:0] sample_left,
    input  logic [23:0] sample_right,
    input  logic        sample_valid,
    input  logic        mute,
    output logic        next_sample,
    output logic        lrclk,
    output logic        data,
    output logic        underrun,
    output logic [7:0]  underrun_count
);
    localparam int FRAME = 2 * SLOT_BITS;
    localparam int CW = $clog2(FRAME);
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);
    localparam logic [CW-1:0] SLOT = CW'(SLOT_BITS);
    localparam logic [CW-1:0] SB = CW'(SAMPLE_BITS);
    localparam logic [CW-1:0] ONE = CW'(1);
    logic [CW-1:0] cnt, n, m;
    logic [23:0] l_reg, r_reg, l_sh, r_sh;
    logic armed, data_n;
    always_comb begin
        n = (cnt == LAST) ? '0 : cnt + ONE;
        m = (I2S_DELAY != 0) ? ((n == '0) ? LAST : n - ONE) : n;
        l_sh = l_reg << m;
        r_sh = r_reg << (m - SLOT);
        data_n = (m < SB) ? l_sh[23] : ((m >= SLOT) && (m - SLOT < SB)) ? r_sh[23] : 1'b0;
    end
    // armed blocks a strobe that coincides with reset release
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= CW'(FRAME - 3);
            l_reg <= '0;
            r_reg <= '0;
            lrclk <= 1'b1;
            data <= 1'b0;
            next_sample <= 1'b0;
            underrun <= 1'b0;
            underrun_count <= '0;
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
            next_sample <= 1'b0;
            underrun <= 1'b0;
            if (armed && strobe) begin
                cnt <= n;
                lrclk <= (n >= SLOT);
                data <= data_n;
                next_sample <= (n == LAST - ONE);
                if (n == LAST) begin
                    if (mute) begin
                        l_reg <= '0;
                        r_reg <= '0;
                    end else if (sample_valid) begin
                        l_reg <= sample_left;
                        r_reg <= sample_right;
                    end else begin
                        underrun <= 1'b1;
                        if (underrun_count != 8'hFF) underrun_count <= underrun_count + 8'd1;
                    end
                end
            end
        end
    end
endmodule
